sr_harmonic_oscillator_bank: RTL



---
 rtl/sr_harmonic_oscillator_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sr_harmonic_oscillator_bank.sv
// sr_harmonic_oscillator_bank: time-multiplexed phase accumulators with quarter-wave sine LUT and summed composite.
// Optional SR_HARMONIC_MASK_EN adds a harmonic_mask input that excludes masked harmonics from sum_out.
module sr_harmonic_oscillator_bank #(
    parameter int WIDTH         = 18,
    parameter int FRAC          = 14,
    parameter int NUM_HARMONICS = 5,
    parameter int PHASE_W       = 17
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic [NUM_HARMONICS*WIDTH-1:0]   omega_dt_packed,
`ifdef SR_HARMONIC_MASK_EN
    input  logic [NUM_HARMONICS-1:0]         harmonic_mask,
`endif
    output logic [NUM_HARMONICS*PHASE_W-1:0] phase_packed,
    output logic [NUM_HARMONICS*16-1:0]      sine_packed,
    output logic [WIDTH-1:0]                 sum_out,
    output logic                             sample_valid,
    output logic                             busy,
    output logic [7:0]                       overrun_count
);
    localparam int TWO_PI = int'(6.283185307179586 * real'(1 << FRAC));
    localparam int IW = NUM_HARMONICS > 1 ? $clog2(NUM_HARMONICS) : 1;
    localparam int SW = (WIDTH > PHASE_W ? WIDTH : PHASE_W) + 2;
    localparam int AW = 16 + $clog2(NUM_HARMONICS + 1) > WIDTH + 1 ? 16 + $clog2(NUM_HARMONICS + 1) : WIDTH + 1;
    localparam logic signed [SW-1:0] TP   = SW'(TWO_PI);
    localparam logic signed [SW-1:0] TP1  = SW'(TWO_PI - 1);
    localparam logic signed [AW-1:0] SMAX = AW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACC = 2'd1, S_DRAIN = 2'd2, S_OUT = 2'd3;
    localparam logic [13:0] QTAB [0:64] = '{
        14'd0,     14'd402,   14'd804,   14'd1205,  14'd1606,  14'd2005,  14'd2404,  14'd2801,
        14'd3196,  14'd3590,  14'd3981,  14'd4370,  14'd4756,  14'd5139,  14'd5519,  14'd5896,
        14'd6270,  14'd6639,  14'd7005,  14'd7366,  14'd7723,  14'd8075,  14'd8423,  14'd8765,
        14'd9102,  14'd9433,  14'd9759,  14'd10079, 14'd10393, 14'd10701, 14'd11002, 14'd11297,
        14'd11585, 14'd11865, 14'd12139, 14'd12405, 14'd12664, 14'd12915, 14'd13159, 14'd13394,
        14'd13622, 14'd13841, 14'd14052, 14'd14255, 14'd14449, 14'd14634, 14'd14810, 14'd14977,
        14'd15136, 14'd15285, 14'd15425, 14'd15556, 14'd15678, 14'd15790, 14'd15892, 14'd15985,
        14'd16068, 14'd16142, 14'd16206, 14'd16260, 14'd16304, 14'd16339, 14'd16363, 14'd16378,
        14'd16383
    };

    logic [1:0]                     state_q, state_d;
    logic [IW-1:0]                  idx_q, l_q;
    logic                           v_q, valid_q;
    logic [NUM_HARMONICS*WIDTH-1:0] omega_q;
    logic [PHASE_W-1:0]             phase_q [NUM_HARMONICS];
    logic signed [15:0]             sine_q [NUM_HARMONICS];
    logic signed [AW-1:0]           acc_q;
    logic [WIDTH-1:0]               sum_q;
    logic [7:0]                     ovr_q;
    logic signed [WIDTH-1:0]        om;
    logic signed [SW-1:0]           om_x, om_c, p;
    logic [PHASE_W-1:0]             phase_d;
    logic [PHASE_W+7:0]             prod;
    logic [7:0]                     lidx;
    logic [6:0]                     k;
    logic signed [15:0]             sine_d;
    logic signed [AW-1:0]           add_v;
`ifdef SR_HARMONIC_MASK_EN
    logic [NUM_HARMONICS-1:0]       mask_q;
`endif

    always_comb begin
        om      = omega_q[idx_q*WIDTH +: WIDTH];
        om_x    = SW'(om);
        om_c    = om_x > TP1 ? TP1 : om_x < -TP1 ? -TP1 : om_x;
        p       = $signed(SW'(phase_q[idx_q])) + om_c;
        phase_d = PHASE_W'(p >= TP ? p - TP : p < 0 ? p + TP : p);
        // 163/65536 approximates 256/TWO_PI, mapping phase onto a 256-entry full wave
        prod    = (PHASE_W+8)'(phase_q[l_q]) * (PHASE_W+8)'(163);
        lidx    = (prod >> 16) > 255 ? 8'hff : 8'(prod >> 16);
        k       = lidx[6] ? 7'd64 - {1'b0, lidx[5:0]} : {1'b0, lidx[5:0]};
        sine_d  = lidx[7] ? -$signed({2'b0, QTAB[k]}) : $signed({2'b0, QTAB[k]});
`ifdef SR_HARMONIC_MASK_EN
        add_v   = mask_q[l_q] ? '0 : AW'(sine_d);
`else
        add_v   = AW'(sine_d);
`endif
        state_d = state_q == S_IDLE  ? (clk_en ? S_ACC : S_IDLE) :
                  state_q == S_ACC   ? (idx_q == IW'(NUM_HARMONICS - 1) ? S_DRAIN : S_ACC) :
                  state_q == S_DRAIN ? S_OUT : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            l_q     <= '0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
            omega_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            ovr_q   <= '0;
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                phase_q[i] <= '0;
                sine_q[i]  <= '0;
            end
`ifdef SR_HARMONIC_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= state_q == S_OUT;
            v_q     <= state_q == S_ACC;
            l_q     <= idx_q;
            if (clk_en && state_q == S_IDLE) begin
                omega_q <= omega_dt_packed;
                idx_q   <= '0;
                acc_q   <= '0;
`ifdef SR_HARMONIC_MASK_EN
                mask_q  <= harmonic_mask;
`endif
            end
            if (clk_en && state_q != S_IDLE && ovr_q != 8'hff)
                ovr_q <= ovr_q + 8'd1;
            if (state_q == S_ACC) begin
                phase_q[idx_q] <= phase_d;
                idx_q          <= idx_q == IW'(NUM_HARMONICS - 1) ? '0 : idx_q + 1'b1;
            end
            if (v_q) begin
                sine_q[l_q] <= sine_d;
                acc_q       <= acc_q + add_v;
            end
            if (state_q == S_OUT)
                sum_q <= WIDTH'(acc_q > SMAX ? SMAX : acc_q < SMIN ? SMIN : acc_q);
        end
    end

    for (genvar g = 0; g < NUM_HARMONICS; g++) begin : g_pack
        assign phase_packed[g*PHASE_W +: PHASE_W] = phase_q[g];
        assign sine_packed[g*16 +: 16]            = sine_q[g];
    end

    assign sum_out       = sum_q;
    assign sample_valid  = valid_q;
    assign busy          = state_q != S_IDLE;
    assign overrun_count = ovr_q;
endmodule
